sign_mag_accum: RTL and testbench
=================================

SIGN_MAG_ACCUM -- requirements
Module: sign_mag_accum

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, number of samples per frame, legal range 1..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port clr  input  1  synchronous frame abort.
REQ-005 SHALL have port in_valid  input  1  upstream sum available.
REQ-006 SHALL have port in_ready  output  1  block can accept a sample.
REQ-007 SHALL have port in_sum  input  9  sign-magnitude sample from the sign-magnitude adder: [8] sign (1 = negative), [7:0] magnitude.
REQ-008 SHALL have port out_valid  output  1  frame result available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_sum  output  13  frame total in sign-magnitude: [12] sign, [11:0] magnitude.
REQ-011 SHALL have port frame_cnt  output  5  samples accepted in the current frame.

Function
REQ-012 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-013 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-014 A sample SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-015 On accept, the accumulator SHALL be updated with the sign-magnitude sum of acc and in_sum, and frame_cnt SHALL be incremented by 1.
REQ-016 Sign-magnitude add rules:
- equal signs: magnitudes added, common sign kept;
- different signs: smaller magnitude subtracted from larger, sign of the larger kept;
- equal magnitudes with different signs: result +0.
REQ-017 A zero-magnitude result SHALL always carry sign 0, and an input of -0 (in_sum = 9'h100) SHALL be treated as +0.
REQ-018 No overflow is possible, because 16 x 255 = 4080 < 4096; no saturation logic SHALL be added.
REQ-019 When the accepted sample is the FRAME_LEN-th of the frame, the FSM SHALL enter HOLD on the next edge, with out_sum equal to the final total (latency 1 cycle from the last accept to out_valid).
REQ-020 out_sum SHALL be driven directly from the accumulator register, so it shows the running total in ACCUM and stays stable in HOLD.
REQ-021 In HOLD, when out_valid and out_ready are both 1, on that edge acc SHALL become +0, frame_cnt SHALL become 0 and the FSM SHALL return to ACCUM.
REQ-022 No sample SHALL be accepted in the cycle a result is handed off; exactly one bubble cycle occurs per frame.
REQ-023 While out_ready is 0 in HOLD, out_sum, frame_cnt and out_valid SHALL hold unchanged indefinitely.
REQ-024 clr = 1 SHALL force acc to +0, frame_cnt to 0 and the state to ACCUM on the next edge, in any state.
REQ-025 clr SHALL take priority over a simultaneous input accept or output handoff, and any sample presented in that cycle SHALL be discarded.
REQ-026 With FRAME_LEN = 1, every accepted sample SHALL produce a result frame equal to the normalized input.

Reset
REQ-027 While rst_n = 0, immediately and independent of clk: state = ACCUM, acc = +0 (out_sum = 0), frame_cnt = 0, out_valid = 0, in_ready = 1.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending results.
REQ-029 Operation SHALL resume on the first rising clk edge after rst_n returns to 1.

Verification
REQ-030 Scenario, FRAME_LEN = 3: inputs 9'h113 (-19), 9'h108 (-8), 9'h1D4 (-212), out_ready = 1 -> out_valid for 1 cycle with out_sum = 13'h10EF (-239), frame_cnt = 3.
REQ-031 Scenario, FRAME_LEN = 2: inputs 9'h015 (+21), 9'h115 (-21) -> out_sum = 13'h0000 (+0, sign bit 0).
REQ-032 Scenario, FRAME_LEN = 8: 8 x 9'h1FF (-255) with in_valid held high -> out_sum = 13'h17F8 (-2040); out_valid asserts the cycle after the 8th accept.
REQ-033 Scenario, backpressure: hold out_ready = 0 for 10 cycles in HOLD while in_valid = 1 -> in_ready = 0, out_sum stable, no sample consumed; out_ready = 1 -> handoff, then ACCUM after one bubble.
REQ-034 Scenario, abort: clr pulsed after 2 of 3 samples (+100, -30) -> out_sum = 0, frame_cnt = 0; the next frame's total excludes the aborted samples.
REQ-035 Scenario, reset: rst_n driven low asynchronously in HOLD -> out_valid = 0 and out_sum = 0 before the next clk edge.

Source files
------------

// File: rtl/sign_mag_accum.sv
// Frame accumulator for sign-magnitude samples: sums FRAME_LEN samples and
// presents the sign-magnitude total under a valid/ready handshake.
module sign_mag_accum #(
  parameter int FRAME_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_sum,
  output logic [4:0]  frame_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(FRAME_LEN - 1);

  state_t      state;
  logic        acc_sign;
  logic [11:0] acc_mag;

  logic        in_sign_n;
  logic [11:0] in_mag_x;
  logic        sum_sign;
  logic [11:0] sum_mag;
  logic        accept;
  logic        last_sample;

  // 16 x 255 fits in 12 bits, so the magnitude never needs saturation.
  assign out_sum     = {acc_sign, acc_mag};
  assign accept      = in_valid && in_ready;
  assign last_sample = (frame_cnt == LAST_CNT);

  // NOTE: every output of always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    in_mag_x  = {4'd0, in_sum[7:0]};
    in_sign_n = in_sum[8] && (in_sum[7:0] != 8'd0);
    sum_mag   = '0;
    sum_sign  = 1'b0;
    if (acc_sign == in_sign_n) begin
      sum_mag  = acc_mag + in_mag_x;
      sum_sign = acc_sign;
    end else if (acc_mag >= in_mag_x) begin
      sum_mag  = acc_mag - in_mag_x;
      sum_sign = acc_sign;
    end else begin
      sum_mag  = in_mag_x - acc_mag;
      sum_sign = in_sign_n;
    end
    // A zero result is always +0, whatever the operand signs were.
    if (sum_mag == 12'd0) begin
      sum_sign = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc_sign  <= 1'b0;
      acc_mag   <= '0;
      frame_cnt <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= ACCUM;
      acc_sign  <= 1'b0;
      acc_mag   <= '0;
      frame_cnt <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_sign  <= sum_sign;
            acc_mag   <= sum_mag;
            frame_cnt <= frame_cnt + 5'd1;
            if (last_sample) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Handoff cycle is the per-frame bubble: in_ready is still low here.
          if (out_ready) begin
            state     <= ACCUM;
            acc_sign  <= 1'b0;
            acc_mag   <= '0;
            frame_cnt <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_mag_accum.sv
// Self-checking bench: four accumulators (FRAME_LEN 1, 2, 3, 8) share one
// stimulus stream and are compared against an integer-arithmetic model.
module tb_sign_mag_accum;

  localparam int NDUT = 4;
  localparam int LENS [NDUT] = '{1, 2, 3, 8};

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [8:0] in_sum;
  logic       out_ready;

  logic        in_ready_w  [NDUT];
  logic        out_valid_w [NDUT];
  logic [12:0] out_sum_w   [NDUT];
  logic [4:0]  frame_cnt_w [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      sign_mag_accum #(.FRAME_LEN(LENS[g])) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[g]),
        .in_sum    (in_sum),
        .out_valid (out_valid_w[g]),
        .out_ready (out_ready),
        .out_sum   (out_sum_w[g]),
        .frame_cnt (frame_cnt_w[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed integer total, sample count, holding flag.
  int m_total [NDUT];
  int m_cnt   [NDUT];
  bit m_hold  [NDUT];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n || clr) begin
        m_total[k] = 0;
        m_cnt[k]   = 0;
        m_hold[k]  = 1'b0;
      end else if (m_hold[k]) begin
        if (out_ready) begin
          m_total[k] = 0;
          m_cnt[k]   = 0;
          m_hold[k]  = 1'b0;
        end
      end else if (in_valid) begin
        m_total[k] += in_sum[8] ? -int'(in_sum[7:0]) : int'(in_sum[7:0]);
        m_cnt[k]   += 1;
        if (m_cnt[k] == LENS[k]) m_hold[k] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int          mag;
    logic [12:0] e_sum;
    for (int k = 0; k < NDUT; k++) begin
      mag   = (m_total[k] < 0) ? -m_total[k] : m_total[k];
      e_sum = {(m_total[k] < 0), mag[11:0]};
      check($sformatf("%s len%0d out_sum", tag, LENS[k]), 32'(out_sum_w[k]), 32'(e_sum));
      check($sformatf("%s len%0d frame_cnt", tag, LENS[k]), 32'(frame_cnt_w[k]), 32'(m_cnt[k]));
      check($sformatf("%s len%0d out_valid", tag, LENS[k]), 32'(out_valid_w[k]), 32'(m_hold[k]));
      check($sformatf("%s len%0d in_ready", tag, LENS[k]), 32'(in_ready_w[k]), 32'(!m_hold[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic [8:0] s, input logic r);
    clr       = c;
    in_valid  = v;
    in_sum    = s;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 9'h000, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        clr;
    logic        vld;
    logic [8:0]  sum;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [12:0] e_sum;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic c, input logic v, input logic [8:0] s, input logic r,
                              input logic er, input logic ev, input logic [12:0] es,
                              input logic [4:0] ec);
    vec_t t;
    t.clr = c; t.vld = v; t.sum = s; t.ordy = r;
    t.e_rdy = er; t.e_vld = ev; t.e_sum = es; t.e_cnt = ec;
    return t;
  endfunction

  initial begin
    logic [12:0] held_sum;

    // Expected state of the FRAME_LEN=3 instance after each row's edge.
    vecs[0]  = mk(0, 1, 9'h113, 1, 1, 0, 13'h1013, 5'd1);
    vecs[1]  = mk(0, 1, 9'h108, 1, 1, 0, 13'h101B, 5'd2);
    vecs[2]  = mk(0, 1, 9'h1D4, 1, 0, 1, 13'h10EF, 5'd3);
    vecs[3]  = mk(0, 1, 9'h015, 1, 1, 0, 13'h0000, 5'd0);
    vecs[4]  = mk(0, 1, 9'h015, 1, 1, 0, 13'h0015, 5'd1);
    vecs[5]  = mk(0, 1, 9'h115, 1, 1, 0, 13'h0000, 5'd2);
    vecs[6]  = mk(1, 1, 9'h064, 1, 1, 0, 13'h0000, 5'd0);
    vecs[7]  = mk(0, 1, 9'h064, 1, 1, 0, 13'h0064, 5'd1);
    vecs[8]  = mk(0, 1, 9'h11E, 1, 1, 0, 13'h0046, 5'd2);
    vecs[9]  = mk(1, 0, 9'h000, 1, 1, 0, 13'h0000, 5'd0);
    vecs[10] = mk(0, 1, 9'h005, 1, 1, 0, 13'h0005, 5'd1);
    vecs[11] = mk(0, 1, 9'h100, 1, 1, 0, 13'h0005, 5'd2);
    vecs[12] = mk(0, 1, 9'h10A, 1, 0, 1, 13'h1005, 5'd3);
    vecs[13] = mk(0, 1, 9'h0AA, 0, 0, 1, 13'h1005, 5'd3);
    vecs[14] = mk(0, 1, 9'h1FF, 1, 1, 0, 13'h0000, 5'd0);

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 9'h000, 1'b0);
    do_reset();
    #1;
    check("reset out_sum", 32'(out_sum_w[2]), 32'h0);
    check("reset in_ready", 32'(in_ready_w[2]), 32'h1);
    check_all("reset");

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].clr, vecs[i].vld, vecs[i].sum, vecs[i].ordy);
      tick();
      check($sformatf("vec%0d out_sum", i), 32'(out_sum_w[2]), 32'(vecs[i].e_sum));
      check($sformatf("vec%0d frame_cnt", i), 32'(frame_cnt_w[2]), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid_w[2]), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready_w[2]), 32'(vecs[i].e_rdy));
      check_all($sformatf("vec%0d", i));
    end

    // Eight -255 samples back to back into the FRAME_LEN=8 instance, then backpressure.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 9'h1FF, 1'b0);
      tick();
      check($sformatf("len8 burst%0d out_valid", i), 32'(out_valid_w[3]), 32'(i == 7));
      check_all($sformatf("burst%0d", i));
    end
    check("len8 total", 32'(out_sum_w[3]), 32'h17F8);
    held_sum = out_sum_w[3];
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 9'h011, 1'b0);
      tick();
      check($sformatf("len8 stall%0d out_sum", i), 32'(out_sum_w[3]), 32'(held_sum));
      check($sformatf("len8 stall%0d frame_cnt", i), 32'(frame_cnt_w[3]), 32'd8);
      check($sformatf("len8 stall%0d in_ready", i), 32'(in_ready_w[3]), 32'd0);
      check_all($sformatf("stall%0d", i));
    end
    drive(1'b0, 1'b1, 9'h011, 1'b1);
    tick();
    check("len8 handoff frame_cnt", 32'(frame_cnt_w[3]), 32'd0);
    check("len8 handoff out_valid", 32'(out_valid_w[3]), 32'd0);
    check_all("handoff");
    drive(1'b0, 1'b1, 9'h011, 1'b1);
    tick();
    check("len8 after bubble out_sum", 32'(out_sum_w[3]), 32'h0011);
    check_all("bubble");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            9'($urandom_range(0, 511)), ($urandom_range(0, 4) < 3));
      tick();
      check_all($sformatf("rand%0d", i));
    end

    // Asynchronous reset while the FRAME_LEN=1 instance holds a result.
    do_reset();
    drive(1'b0, 1'b1, 9'h0AB, 1'b0);
    tick();
    check("len1 hold out_valid", 32'(out_valid_w[0]), 32'd1);
    check("len1 hold out_sum", 32'(out_sum_w[0]), 32'h00AB);
    drive(1'b0, 1'b0, 9'h000, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid_w[0]), 32'd0);
    check("async rst out_sum", 32'(out_sum_w[0]), 32'h0);
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 9'h003, 1'b1);
    tick();
    check("post rst len8 out_sum", 32'(out_sum_w[3]), 32'h0003);
    check_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
